sad_min_select: RTL and testbench
=================================

SAD_MIN_SELECT -- requirements
Module: sad_min_select

Interface
REQ-001 The block SHALL run on one clock and use an asynchronous, active-high reset.
REQ-002 Parameters SHALL be (name, default, meaning):
- SAD_W, 14: SAD width.
- SEARCH_R, 4: search radius in pixels; candidates per block N_CAND = (2*SEARCH_R+1)^2 = 81.
- SUM_LAT, 4: cycles from presenting an 8x8 |diff| vector to the SAD tree until its sum is valid.
- MV_W, 4: signed motion-vector component width.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: clock.
- rst, in, 1: asynchronous active-high reset.
- start, in, 1: one-cycle pulse that opens a new block search.
- cand_valid, in, 1: high in the cycle a candidate's |diff| vector enters the SAD tree.
- sum, in, SAD_W: SAD tree output, unsigned.
- busy, out, 1: search in progress.
- done, out, 1: one-cycle pulse when the result is final.
- best_sad, out, SAD_W: minimum SAD of the search.
- best_mvx, out, MV_W: signed x displacement of the minimum.
- best_mvy, out, MV_W: signed y displacement of the minimum.

Function
REQ-004 The FSM SHALL have four states:
- IDLE -> ISSUE on start.
- ISSUE -> DRAIN when the N_CAND-th cand_valid is accepted.
- DRAIN -> DONE when the N_CAND-th result is compared.
- DONE -> IDLE unconditionally after 1 cycle.
REQ-005 busy SHALL be 1 in ISSUE and DRAIN; done SHALL be 1 only in DONE.
REQ-006 Candidates SHALL be numbered in raster order: mvy outer and mvx inner, each running -SEARCH_R..+SEARCH_R. Candidate 0 = (-4,-4), candidate 40 = (0,0), candidate 80 = (+4,+4).
REQ-007 An issue counter SHALL increment on each cand_valid accepted in ISSUE. cand_valid gaps (stalls) SHALL be allowed.
REQ-008 cand_valid SHALL be ignored in IDLE, DRAIN and DONE.
REQ-009 start SHALL be ignored while busy or done is 1.
REQ-010 A SUM_LAT-deep delay line SHALL carry the valid bit and candidate index, so that each result is paired with the sum of the candidate issued SUM_LAT cycles earlier.
REQ-011 The first result of a search SHALL load best_sad and best_mv unconditionally.
REQ-012 Each later result SHALL replace the stored best only if sum < best_sad (strict compare); on a tie the earlier candidate is kept.
REQ-013 The compare SHALL be registered at the clock edge on which the delayed valid is high. The result for the last candidate SHALL therefore be compared SUM_LAT cycles after that candidate is issued, with no stall in between.
REQ-014 done SHALL assert the cycle after the N_CAND-th compare. best_* SHALL be stable in that cycle and SHALL hold until the first compare of the next search.
REQ-015 The mv outputs SHALL be index-derived: mvx = (idx mod 9) - SEARCH_R, mvy = (idx div 9) - SEARCH_R, in two's complement.
REQ-016 At full throughput (81 consecutive cand_valid), start-to-done SHALL be 1 + 81 + SUM_LAT cycles.

Reset
REQ-017 Reset SHALL force IDLE, busy=0, done=0, best_sad=all ones (16383), best_mvx=0 and best_mvy=0.
REQ-018 Reset SHALL clear the issue counter and every delay-line valid bit.
REQ-019 Reset asserted mid-search SHALL abort the search. No done SHALL follow, and any in-flight results SHALL be discarded.

Structure
REQ-020 Package sad_pkg SHALL hold SAD_W, SEARCH_R, N_CAND, SUM_LAT, MV_W and the FSM state encoding.
REQ-021 The delay line SHALL be a sub-module, sad_align_delay, parameterised by depth and payload width; its valid bits SHALL reset to 0.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Full-throughput search, sum = 1000 everywhere except candidate 40 = 12 -> done at cycle 86 after start, best_sad=12, mv=(0,0).
- Two candidates tied at minimum 5 (index 3 and index 70) -> mv=(-1,-4); the earlier candidate wins.
- cand_valid toggled every other cycle, minimum 0 at index 80 -> best_sad=0, mv=(+4,+4); done 4 cycles after the last compare issue plus 1.
- start pulsed during ISSUE, and 5 extra cand_valid pulses during DRAIN -> ignored; exactly 81 compares and 1 done.
- rst asserted at issue 30 -> busy=0, best_sad=16383, no done. A fresh search then completes normally.
- All sums = 16383 -> best_sad=16383, mv=(-4,-4), because the first result loads unconditionally.

Source files
------------

// File: rtl/sad_pkg.sv
// Shared constants, FSM encoding and motion-vector helpers for the
// block-matching minimum-SAD selector.
package sad_pkg;

  localparam int SAD_W    = 14;
  localparam int SEARCH_R = 4;
  localparam int N_CAND   = (2*SEARCH_R + 1) * (2*SEARCH_R + 1);
  localparam int SUM_LAT  = 4;
  localparam int MV_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Raster index -> displacement: x is the inner (column) coordinate.
  function automatic int mv_col(input int idx, input int r);
    return (idx % (2*r + 1)) - r;
  endfunction

  function automatic int mv_row(input int idx, input int r);
    return (idx / (2*r + 1)) - r;
  endfunction

endpackage

// File: rtl/sad_align_delay.sv
// Fixed-depth shift register carrying a valid bit and a payload, used to
// pair each candidate index with its SAD once the adder tree has produced it.
module sad_align_delay #(
  parameter int DEPTH = 4,
  parameter int W     = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic [DEPTH-1:0] vld;
  logic [W-1:0]     dat [DEPTH];

  // Valid bits are reset so an aborted search leaves nothing in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
    end else begin
      vld[0] <= in_valid;
      for (int i = 1; i < DEPTH; i++) begin
        vld[i] <= vld[i-1];
      end
    end
  end

  // Payload only matters alongside its valid bit, so it needs no reset.
  always_ff @(posedge clk) begin
    dat[0] <= in_data;
    for (int i = 1; i < DEPTH; i++) begin
      dat[i] <= dat[i-1];
    end
  end

  assign out_valid = vld[DEPTH-1];
  assign out_data  = dat[DEPTH-1];

endmodule

// File: rtl/sad_min_select.sv
// Sequences candidate issue for one block search and tracks the running
// minimum SAD together with the displacement that produced it.
module sad_min_select
  import sad_pkg::*;
#(
  parameter int SAD_W    = sad_pkg::SAD_W,
  parameter int SEARCH_R = sad_pkg::SEARCH_R,
  parameter int SUM_LAT  = sad_pkg::SUM_LAT,
  parameter int MV_W     = sad_pkg::MV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cand_valid,
  input  logic [SAD_W-1:0] sum,
  output logic             busy,
  output logic             done,
  output logic [SAD_W-1:0] best_sad,
  output logic [MV_W-1:0]  best_mvx,
  output logic [MV_W-1:0]  best_mvy
);

  localparam int DIM    = 2*SEARCH_R + 1;
  localparam int N_CAND = DIM * DIM;
  localparam int IDX_W  = $clog2(N_CAND);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CAND - 1);

  state_t           state;
  logic [IDX_W-1:0] issue_cnt;
  logic [IDX_W-1:0] cmp_cnt;
  logic [IDX_W-1:0] res_idx;
  logic             first;
  logic             accept;
  logic             res_valid;
  logic             take;
  logic [MV_W-1:0]  res_mvx;
  logic [MV_W-1:0]  res_mvy;

  assign accept = cand_valid && (state == ST_ISSUE);

  sad_align_delay #(
    .DEPTH (SUM_LAT),
    .W     (IDX_W)
  ) u_align (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (accept),
    .in_data   (issue_cnt),
    .out_valid (res_valid),
    .out_data  (res_idx)
  );

  // Strict less-than keeps the earlier candidate on ties.
  always_comb begin
    take    = 1'b0;
    res_mvx = MV_W'(mv_col(int'(res_idx), SEARCH_R));
    res_mvy = MV_W'(mv_row(int'(res_idx), SEARCH_R));
    if (res_valid) begin
      take = first || (sum < best_sad);
    end else begin
      take = 1'b0;
    end
  end

  // Search sequencer with registered busy/done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      issue_cnt <= '0;
      cmp_cnt   <= '0;
      first     <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_ISSUE;
            busy      <= 1'b1;
            issue_cnt <= '0;
            cmp_cnt   <= '0;
            first     <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (accept) begin
            issue_cnt <= issue_cnt + IDX_W'(1);
            if (issue_cnt == LAST_IDX) begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
      // Results only arrive after their issue, so the last one lands in DRAIN.
      if (res_valid && (state == ST_ISSUE || state == ST_DRAIN)) begin
        cmp_cnt <= cmp_cnt + IDX_W'(1);
        first   <= 1'b0;
        if (cmp_cnt == LAST_IDX) begin
          state <= ST_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      end
    end
  end

  // Best-so-far registers hold across searches until the next first compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_sad <= {SAD_W{1'b1}};
      best_mvx <= '0;
      best_mvy <= '0;
    end else if (take) begin
      best_sad <= sum;
      best_mvx <= res_mvx;
      best_mvy <= res_mvy;
    end
  end

endmodule

// File: tb/tb_sad_min_select.sv
// Randomised scoreboard bench for sad_min_select: the driver models the SAD
// tree latency, an argmin reference predicts each result, a monitor checks done.
module tb_sad_min_select;

  localparam int SUM_LAT = 4;
  localparam int NC      = 81;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        cand_valid;
  logic [13:0] sum;
  logic        busy;
  logic        done;
  logic [13:0] best_sad;
  logic [3:0]  best_mvx;
  logic [3:0]  best_mvy;

  typedef struct {
    int sad;
    int mvx;
    int mvy;
    int cyc;
  } exp_t;

  exp_t        sb[$];
  logic [13:0] hist[$];
  int          sums[NC];
  int          cyc = 0;
  int          last_issue;
  int          checks = 0;
  int          errors = 0;

  sad_min_select dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cand_valid (cand_valid),
    .sum        (sum),
    .busy       (busy),
    .done       (done),
    .best_sad   (best_sad),
    .best_mvx   (best_mvx),
    .best_mvy   (best_mvy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One cycle of stimulus; sum replays what was issued SUM_LAT cycles ago.
  task automatic drive(input logic st, input logic cv, input logic [13:0] v);
    logic [13:0] junk;
    start      = st;
    cand_valid = cv;
    hist.push_back(v);
    if (hist.size() > SUM_LAT + 1) junk = hist.pop_front();
    sum = (hist.size() == SUM_LAT + 1) ? hist[0] : 14'($urandom_range(0, 16383));
    if (cv) last_issue = cyc;
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t ref_model();
    exp_t e;
    int   bi;
    bi = 0;
    for (int i = 1; i < NC; i++) if (sums[i] < sums[bi]) bi = i;
    e.sad = sums[bi];
    e.mvx = (bi % 9) - 4;
    e.mvy = (bi / 9) - 4;
    e.cyc = 0;
    return e;
  endfunction

  // mode: 0 full rate, 1 every other cycle, 2 random stalls.
  // abort_at >= 0 resets the block after that many issues.
  task automatic run_search(input int mode, input bit noise, input int abort_at);
    exp_t e;
    int   i;
    int   k;
    int   s_cyc;
    logic cv;
    logic st;
    e     = ref_model();
    s_cyc = cyc;
    drive(1'b1, 1'b0, 14'd0);
    chk("busy_after_start", int'(busy), 1);
    i = 0;
    k = 0;
    while (i < NC) begin
      if (abort_at >= 0 && i == abort_at) begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 14'd0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_best_sad", int'(best_sad), 16383);
        chk("abort_mvx", int'($signed(best_mvx)), 0);
        rst = 1'b0;
        repeat (12) drive(1'b0, 1'b1, 14'd1);
        return;
      end
      case (mode)
        0: cv = 1'b1;
        1: cv = (k % 2 == 1);
        default: cv = ($urandom_range(0, 3) != 0);
      endcase
      st = noise && (i == 10 || i == 40);
      drive(st, cv, cv ? 14'(sums[i]) : 14'($urandom_range(0, 16383)));
      if (cv) i++;
      k++;
    end
    e.cyc = (mode == 0) ? s_cyc + 1 + NC + SUM_LAT : last_issue + SUM_LAT + 1;
    sb.push_back(e);
    for (int d = 0; d < 8; d++) drive(1'b0, noise && d < 5, 14'($urandom_range(0, 16383)));
    k = 0;
    while (sb.size() != 0 && k < 300) begin
      drive(1'b0, 1'b0, 14'd0);
      k++;
    end
    if (sb.size() != 0) begin
      chk("done_timeout", 0, 1);
      sb.delete();
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding prediction.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("best_sad", int'(best_sad), e.sad);
        chk("best_mvx", int'($signed(best_mvx)), e.mvx);
        chk("best_mvy", int'($signed(best_mvy)), e.mvy);
        chk("done_cycle", cyc, e.cyc);
        chk("busy_at_done", int'(busy), 0);
      end
    end
  end

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    cand_valid = 1'b0;
    sum        = 14'd0;
    last_issue = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_best_sad", int'(best_sad), 16383);
    chk("rst_mvx", int'($signed(best_mvx)), 0);
    chk("rst_mvy", int'($signed(best_mvy)), 0);
    rst = 1'b0;
    drive(1'b0, 1'b1, 14'd7);
    drive(1'b0, 1'b0, 14'd0);

    for (int i = 0; i < NC; i++) sums[i] = 1000;
    sums[40] = 12;
    run_search(0, 1'b0, -1);

    for (int i = 0; i < NC; i++) sums[i] = $urandom_range(6, 16383);
    sums[3]  = 5;
    sums[70] = 5;
    run_search(0, 1'b0, -1);

    for (int i = 0; i < NC; i++) sums[i] = $urandom_range(1, 16383);
    sums[80] = 0;
    run_search(1, 1'b0, -1);

    for (int i = 0; i < NC; i++) sums[i] = $urandom_range(0, 16383);
    run_search(0, 1'b1, -1);

    for (int i = 0; i < NC; i++) sums[i] = $urandom_range(0, 16383);
    run_search(0, 1'b0, 30);
    for (int i = 0; i < NC; i++) sums[i] = $urandom_range(0, 16383);
    run_search(2, 1'b0, -1);

    for (int i = 0; i < NC; i++) sums[i] = 16383;
    run_search(0, 1'b0, -1);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NC; i++) sums[i] = $urandom_range(0, 20);
      run_search(2, r[0], -1);
    end

    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
